// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one synchronous FIFO write port.
// Optional stall statistics: define FIFO_ARB_STALL_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata_in,
  output logic [NREQ-1:0]       gnt,
  input  logic                  fifo_full,
  output logic                  fifo_wen,
  output logic [WIDTH-1:0]      fifo_wdata,
  output logic [15:0]           stall_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] BMAX = CW'(BURST);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [NREQ-1:0] gnt_nx;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_nx;
  logic [IW-1:0]   last;
  logic [IW-1:0]   last_nx;
  logic [CW-1:0]   beats;
  logic [CW-1:0]   beats_nx;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic            own_req;
  logic            xfer;
  logic            done;
  int              j;
  logic [IW-1:0]   jj;

  // Round-robin search upward from the slot after the last owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    j        = 0;
    jj       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j  = (int'(last) + i) % NREQ;
      jj = IW'(j);
      if (!pick_vld && req[jj]) begin
        pick     = jj;
        pick_vld = 1'b1;
      end
    end
  end

  // Transfer / burst-end qualifiers for the current owner.
  always_comb begin
    own_req = req[owner];
    xfer    = rstn && (state == GRANT)
              && own_req && !fifo_full;
    done    = (state == GRANT)
              && (!own_req
                  || (xfer && ((beats + CW'(1)) == BMAX)));
  end

  assign fifo_wen = xfer;

  // Owner data slice is only visible while granted.
  always_comb begin
    fifo_wdata = '0;
    if (state == GRANT) begin
      fifo_wdata = wdata_in[owner*WIDTH +: WIDTH];
    end
  end

  // Next-state logic for the two-state grant FSM.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    owner_nx = owner;
    last_nx  = last;
    beats_nx = beats;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = GRANT;
          owner_nx = pick;
          gnt_nx   = '0;
          gnt_nx[pick] = 1'b1;
          beats_nx = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beats_nx = beats + CW'(1);
        end
        if (done) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          last_nx  = owner;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  // FSM and grant bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      last  <= LAST_RST;
      beats <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      owner <= owner_nx;
      last  <= last_nx;
      beats <= beats_nx;
    end
  end

`ifdef FIFO_ARB_STALL_STATS_EN
  logic        stall;
  logic [15:0] stall_q;

  assign stall = (state == GRANT)
                 && own_req && fifo_full;

  // Saturating count of owner cycles blocked by a full FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
